// File: rtl/reg_arb_pkg.sv
// Shared types and defaults for the two-port register bank arbiter.
package reg_arb_pkg;

  localparam int DEF_DATA_W   = 8;
  localparam int DEF_ADDR_W   = 3;
  localparam int DEF_MAX_HOLD = 4;

  // Port indices: 0 = CPU datapath, 1 = I/O / loader.
  localparam int PORT0 = 0;
  localparam int PORT1 = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_e;

  // Ownership state for a given port index.
  function automatic arb_state_e own_state(input logic port);
    return port ? ST_OWN1 : ST_OWN0;
  endfunction

endpackage

// File: rtl/reg_bank.sv
// Array of DATA_W-bit registers with one synchronous write/read port.
// The read data is registered; clr zeroes every register and the read latch.
module reg_bank
  import reg_arb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];

  // Register array update and registered read.
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
      rdata <= '0;
    end else begin
      if (we) begin
        regs[addr] <= wdata;
      end
      if (re) begin
        rdata <= regs[addr];
      end
    end
  end

endmodule

// File: rtl/reg_bank_arbiter.sv
// Round-robin arbiter sharing one register bank between two ports.
// Handshake: a port raises req and waits for gnt (one cycle after the sampled
// req at best); every cycle with gnt & req is one access. Writes commit at that
// edge; a read pulses rvalid for the following cycle with rdata, and rdata holds
// afterwards. lock asks to keep ownership after the access; if the other port is
// waiting, a locked owner is limited to MAX_HOLD consecutive accesses.
module reg_bank_arbiter
  import reg_arb_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              req0,
  input  logic              lock0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              lock1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,
  output logic [1:0]        dbg_state
);

  localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  arb_state_e        state, state_nx;
  logic              last, last_nx;
  logic [HOLD_W-1:0] hold, hold_nx;

  logic              owner;
  logic              cur_req, cur_lock, cur_we, oth_req;
  logic              access0, access1, access;
  logic              rel;
  logic              bank_we, bank_re;
  logic [ADDR_W-1:0] bank_addr;
  logic [DATA_W-1:0] bank_wdata, bank_rdata;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;

  // Owner-relative view of the request lines; only meaningful in OWN0/OWN1.
  assign owner      = (state == ST_OWN1) ? 1'(PORT1) : 1'(PORT0);
  assign cur_req    = owner ? req1  : req0;
  assign cur_lock   = owner ? lock1 : lock0;
  assign cur_we     = owner ? we1   : we0;
  assign oth_req    = owner ? req0  : req1;
  assign access0    = (state == ST_OWN0) && req0;
  assign access1    = (state == ST_OWN1) && req1;
  assign access     = access0 || access1;

  // The non-owner's inputs never reach the bank.
  assign bank_we    = access && cur_we;
  assign bank_re    = access && !cur_we;
  assign bank_addr  = owner ? addr1  : addr0;
  assign bank_wdata = owner ? wdata1 : wdata0;

  assign gnt0      = (state == ST_OWN0);
  assign gnt1      = (state == ST_OWN1);
  assign dbg_state = state;

  // While rvalid is high the fresh bank read is forwarded; otherwise the
  // port shows the last value it read.
  assign rdata0 = rvalid0 ? bank_rdata : rdata0_q;
  assign rdata1 = rvalid1 ? bank_rdata : rdata1_q;

  reg_bank #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_bank (
    .clk  (clk),
    .clr  (clr),
    .we   (bank_we),
    .re   (bank_re),
    .addr (bank_addr),
    .wdata(bank_wdata),
    .rdata(bank_rdata)
  );

  // Next state, priority pointer and hold count.
  always_comb begin
    state_nx = state;
    last_nx  = last;
    hold_nx  = hold;
    rel      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req0 && req1) begin
          state_nx = own_state(!last);
        end else if (req0) begin
          state_nx = ST_OWN0;
        end else if (req1) begin
          state_nx = ST_OWN1;
        end
      end
      ST_OWN0, ST_OWN1: begin
        rel = !cur_req || !cur_lock || (oth_req && (hold == HOLD_LAST));
        if (rel) begin
          last_nx  = owner;
          hold_nx  = '0;
          state_nx = oth_req ? own_state(!owner) : ST_IDLE;
        end else if (hold != HOLD_LAST) begin
          hold_nx = hold + 1'b1;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Arbiter state register.
  always_ff @(posedge clk) begin
    if (clr) begin
      state <= ST_IDLE;
      last  <= 1'b1;
      hold  <= '0;
    end else begin
      state <= state_nx;
      last  <= last_nx;
      hold  <= hold_nx;
    end
  end

  // Read-valid pulses and per-port read-data hold registers.
  always_ff @(posedge clk) begin
    if (clr) begin
      rvalid0  <= 1'b0;
      rvalid1  <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      rvalid0 <= access0 && !we0;
      rvalid1 <= access1 && !we1;
      if (rvalid0) begin
        rdata0_q <= bank_rdata;
      end
      if (rvalid1) begin
        rdata1_q <= bank_rdata;
      end
    end
  end

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Bench for reg_bank_arbiter: directed scenarios with literal expectations,
// then randomized traffic, all cross-checked against a behavioural model.
module tb_reg_bank_arbiter;
  import reg_arb_pkg::*;

  localparam int MAX_HOLD = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       clr = 1'b1;
  logic [1:0] req  = '0;
  logic [1:0] lock = '0;
  logic [1:0] we   = '0;
  logic [2:0] addr  [2];
  logic [7:0] wdata [2];

  logic       gnt0, gnt1, rvalid0, rvalid1;
  logic [7:0] rdata0, rdata1;
  logic [1:0] dbg_state;

  reg_bank_arbiter #(.DATA_W(8), .ADDR_W(3), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .clr(clr),
    .req0(req[0]), .lock0(lock[0]), .we0(we[0]), .addr0(addr[0]), .wdata0(wdata[0]),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req[1]), .lock1(lock[1]), .we1(we[1]), .addr1(addr[1]), .wdata1(wdata[1]),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // owner: -1 = nobody, else port index. Updated on each rising edge from the
  // inputs that were stable before it.
  int         m_own;
  int         m_last;
  int         m_hold;
  logic [7:0] m_bank [8];
  bit         m_rv   [2];
  logic [7:0] m_rdata[2];

  always @(posedge clk) begin
    int x, o;
    bit acc, rel;
    if (clr) begin
      m_own = -1; m_last = 1; m_hold = 0;
      for (int i = 0; i < 8; i++) m_bank[i] = 8'h00;
      m_rv[0] = 0; m_rv[1] = 0;
      m_rdata[0] = 8'h00; m_rdata[1] = 8'h00;
    end else begin
      m_rv[0] = 0; m_rv[1] = 0;
      if (m_own < 0) begin
        if (req[0] && req[1]) m_own = 1 - m_last;
        else if (req[0])      m_own = 0;
        else if (req[1])      m_own = 1;
      end else begin
        x   = m_own;
        o   = 1 - x;
        acc = req[x];
        if (acc) begin
          if (we[x]) m_bank[addr[x]] = wdata[x];
          else begin
            m_rdata[x] = m_bank[addr[x]];
            m_rv[x]    = 1;
          end
        end
        rel = !acc || !lock[x] || (req[o] && m_hold == MAX_HOLD - 1);
        if (rel) begin
          m_last = x;
          m_hold = 0;
          m_own  = req[o] ? o : -1;
        end else if (m_hold < MAX_HOLD - 1) begin
          m_hold = m_hold + 1;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("gnt0",    gnt0,    32'(m_own == 0));
      chk("gnt1",    gnt1,    32'(m_own == 1));
      chk("mutex",   32'(gnt0 & gnt1), 32'd0);
      chk("rvalid0", rvalid0, 32'(m_rv[0]));
      chk("rvalid1", rvalid1, 32'(m_rv[1]));
      chk("rdata0",  rdata0,  m_rdata[0]);
      chk("rdata1",  rdata1,  m_rdata[1]);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input bit r, input bit l, input bit w,
                          input logic [2:0] a, input logic [7:0] d);
    req[p] = r; lock[p] = l; we[p] = w; addr[p] = a; wdata[p] = d;
  endtask

  task automatic idle_all();
    set_port(0, 0, 0, 0, 3'd0, 8'h00);
    set_port(1, 0, 0, 0, 3'd0, 8'h00);
  endtask

  task automatic randomize_inputs();
    for (int p = 0; p < 2; p++) begin
      set_port(p, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
               8'($urandom_range(0, 255)));
    end
  endtask

  // clr for 2 cycles with garbage on the inputs, then quiet inputs.
  task automatic do_reset();
    clr = 1'b1;
    randomize_inputs();
    tick();
    randomize_inputs();
    tick();
    clr = 1'b0;
    idle_all();
  endtask

  // ---------------- stimulus ----------------
  int n;

  initial begin
    idle_all();
    tick();
    cmp_en = 1'b1;

    // Reset state and a cleared bank.
    do_reset();
    chk("rst_gnt0", gnt0, 0);
    chk("rst_gnt1", gnt1, 0);
    chk("rst_rvalid0", rvalid0, 0);
    chk("rst_rvalid1", rvalid1, 0);
    chk("rst_rdata0", rdata0, 8'h00);
    chk("rst_rdata1", rdata1, 8'h00);
    chk("rst_state", dbg_state, 32'(ST_IDLE));
    set_port(0, 1, 1, 0, 3'd0, 8'h00);
    tick();
    for (int i = 0; i < 8; i++) begin
      addr[0] = 3'(i);
      tick();
      chk("rst_read_valid", rvalid0, 1);
      chk("rst_read_zero", rdata0, 8'h00);
    end
    idle_all();
    tick();

    // Single-port write then read.
    do_reset();
    set_port(0, 1, 1, 1, 3'd3, 8'hA5);
    tick();
    chk("sp_grant_latency", gnt0, 1);
    tick();
    set_port(0, 1, 0, 0, 3'd3, 8'h00);
    tick();
    chk("sp_rvalid", rvalid0, 1);
    chk("sp_rdata", rdata0, 8'hA5);
    chk("sp_released", gnt0, 0);
    idle_all();
    tick();
    chk("sp_rvalid_pulse", rvalid0, 0);
    chk("sp_rdata_hold", rdata0, 8'hA5);

    // Simultaneous requests alternate, port 0 first, with no idle gap.
    do_reset();
    set_port(0, 1, 0, 0, 3'd1, 8'h00);
    set_port(1, 1, 0, 0, 3'd2, 8'h00);
    tick();
    chk("rr_first_p0", gnt0, 1);
    tick();
    chk("rr_second_p1", gnt1, 1);
    tick();
    chk("rr_third_p0", gnt0, 1);
    idle_all();
    tick();
    tick();

    // Lock bound while the other port waits.
    do_reset();
    set_port(1, 1, 1, 1, 3'd5, 8'h11);
    tick();
    chk("lk_gnt1", gnt1, 1);
    set_port(0, 1, 0, 0, 3'd0, 8'h00);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      if (gnt1) n++;
      wdata[1] = 8'($urandom_range(0, 255));
      tick();
      if (gnt0) break;
    end
    chk("lk_access_count", n, MAX_HOLD);
    chk("lk_handoff", gnt0, 1);
    idle_all();
    tick();
    tick();

    // Lock unbounded without competition.
    do_reset();
    set_port(1, 1, 1, 1, 3'd6, 8'h22);
    tick();
    for (int k = 0; k < 12; k++) begin
      wdata[1] = 8'($urandom_range(0, 255));
      addr[1]  = 3'($urandom_range(0, 7));
      tick();
    end
    chk("lk_unbounded", gnt1, 1);
    idle_all();
    tick();
    tick();

    // Cross-port visibility.
    do_reset();
    set_port(1, 1, 0, 1, 3'd7, 8'h3C);
    tick();
    tick();
    idle_all();
    set_port(0, 1, 0, 0, 3'd7, 8'h00);
    tick();
    tick();
    chk("xp_rvalid0", rvalid0, 1);
    chk("xp_rdata0", rdata0, 8'h3C);
    idle_all();
    tick();

    // clr in the cycle of a read access.
    do_reset();
    set_port(0, 1, 1, 1, 3'd2, 8'h55);
    tick();
    tick();
    set_port(0, 1, 1, 0, 3'd2, 8'h00);
    clr = 1'b1;
    tick();
    chk("clr_no_rvalid", rvalid0, 0);
    chk("clr_gnt0", gnt0, 0);
    clr = 1'b0;
    set_port(0, 1, 0, 0, 3'd2, 8'h00);
    set_port(1, 1, 0, 0, 3'd0, 8'h00);
    tick();
    chk("clr_tie_p0", gnt0, 1);
    tick();
    chk("clr_bank_rvalid", rvalid0, 1);
    chk("clr_bank_zero", rdata0, 8'h00);
    idle_all();
    tick();

    // Randomized traffic, checked by the per-cycle compare.
    for (int c = 0; c < 3000; c++) begin
      clr = ($urandom_range(0, 63) == 0);
      for (int p = 0; p < 2; p++) begin
        set_port(p, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                 8'($urandom_range(0, 255)));
      end
      tick();
    end
    clr = 1'b0;
    idle_all();
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
